register_read_unit: RTL and testbench
=====================================

REGISTER_READ_UNIT -- requirements
Module: register_read_unit

Interface
REQ-001 The block SHALL have parameter: WIDTH, default 16, bit width of each register and of read data.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: regFile  input  8*WIDTH  flattened outputs of 8 registers; register i at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-005 The block SHALL have port: regWrite  input  1  write strobe of the register bank write port (snooped).
REQ-006 The block SHALL have port: wrIdx  input  3  index of the register being written this cycle.
REQ-007 The block SHALL have port: writeData  input  WIDTH  data being written this cycle.
REQ-008 The block SHALL have port: rdReq  input  1  read request valid.
REQ-009 The block SHALL have port: rdIdx  input  3  register index to read.
REQ-010 The block SHALL have port: rdReady  output  1  request accepted on the current edge when rdReq and rdReady are both high.
REQ-011 The block SHALL have port: rdValid  output  1  rdData/rdIdxOut hold a result.
REQ-012 The block SHALL have port: rdData  output  WIDTH  read result.
REQ-013 The block SHALL have port: rdIdxOut  output  3  index the result belongs to.
REQ-014 The block SHALL have port: rdAck  input  1  consumer takes the result on the current edge when rdValid and rdAck are both high.
REQ-015 The block SHALL have port: fwdCount  output  8  saturating count of forwarded reads.

Function
REQ-016 The block SHALL implement a two-state FSM, EMPTY (rdValid=0) and FULL (rdValid=1), with rdValid driven directly from the state register.
REQ-017 rdReady SHALL be combinational: 1 in EMPTY; equal to rdAck in FULL, giving one accepted read per cycle with back-to-back acks.
REQ-018 Accept = rdReq AND rdReady; take = rdValid AND rdAck.
REQ-019 In EMPTY, accept SHALL move the FSM to FULL; no accept SHALL keep it in EMPTY.
REQ-020 In FULL, take without accept SHALL move the FSM to EMPTY; take with accept SHALL keep it in FULL and load the new result; no take SHALL hold FULL with rdData and rdIdxOut unchanged.
REQ-021 Read latency SHALL be 1 cycle: a request accepted at edge N SHALL present rdValid=1 with its data after edge N.
REQ-022 On accept, rdData SHALL load writeData when regWrite=1 and wrIdx==rdIdx in the accept cycle (forwarding); otherwise it SHALL load the regFile slice selected by rdIdx.
REQ-023 On accept, rdIdxOut SHALL load rdIdx.
REQ-024 Held results SHALL be snapshots: a write to the held index while in FULL SHALL NOT alter rdData.
REQ-025 fwdCount SHALL increment by 1 on each accept that forwards, and SHALL saturate at 255 with no wrap.
REQ-026 rdReq without accept SHALL change no state.
REQ-027 rdAck while in EMPTY SHALL be ignored.
REQ-028 rdIdx values 0-7 SHALL all be valid.

Reset
REQ-029 While reset=0, regardless of clk, the block SHALL force FSM=EMPTY, rdValid=0, rdData=0, rdIdxOut=0 and fwdCount=0.
REQ-030 Reset asserted mid-operation SHALL discard any held result.
REQ-031 After reset deassertion, rdReady SHALL be 1 and the first accept SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-032 The bench SHALL cover: reg3=0x1234, no write; rdReq=1, rdIdx=3 for one cycle, rdAck=1 -> next cycle rdValid=1, rdData=0x1234, rdIdxOut=3; following cycle rdValid=0.
REQ-033 The bench SHALL cover: regWrite=1, wrIdx=5, writeData=0xBEEF, reg5=0x0001, rdReq with rdIdx=5 in the same cycle -> rdData=0xBEEF, fwdCount=1.
REQ-034 The bench SHALL cover: result for reg2=0x00AA held with rdAck=0 for 3 cycles while reg2 is written to 0x5555 -> rdData stays 0x00AA and rdReady=0 throughout.
REQ-035 The bench SHALL cover: rdReq=1 and rdAck=1 continuously with rdIdx stepping 0..7 -> 8 results on 8 consecutive cycles, in order, with no bubbles.
REQ-036 The bench SHALL cover: 300 consecutive forwarding reads -> fwdCount=255 and no wrap.
REQ-037 The bench SHALL cover: reset driven low mid-FULL, between clock edges -> rdValid, rdData, rdIdxOut and fwdCount go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/register_read_unit.sv
// register_read_unit
// One-entry read port in front of an 8-entry register bank. A request
// captures either the bank contents or, when the bank is being written to
// the same index in that cycle, the in-flight write data. The captured
// result is a snapshot that is held until the consumer acknowledges it.
// fwdCount reports how many reads were served by forwarding, saturating
// at 255.

module register_read_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [8*WIDTH-1:0] regFile,
    input  logic               regWrite,
    input  logic [2:0]         wrIdx,
    input  logic [WIDTH-1:0]   writeData,
    input  logic               rdReq,
    input  logic [2:0]         rdIdx,
    output logic               rdReady,
    output logic               rdValid,
    output logic [WIDTH-1:0]   rdData,
    output logic [2:0]         rdIdxOut,
    input  logic               rdAck,
    output logic [7:0]         fwdCount
);

    localparam logic STATE_EMPTY = 1'b0;
    localparam logic STATE_FULL  = 1'b1;

    localparam logic [7:0] FWD_MAX = 8'd255;

    logic             state_reg;
    logic             state_next;
    logic [WIDTH-1:0] data_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       fwd_count_reg;

    logic             accept;
    logic             take;
    logic             forward;
    logic [WIDTH-1:0] read_data;

    // Unpacked view of the flattened register bank.
    logic [WIDTH-1:0] reg_array [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_unpack
            assign reg_array[gi] = regFile[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // Handshake: a full slot can only accept when it is being drained in the same cycle.
    always_comb begin
        rdReady = (state_reg == STATE_EMPTY) ? 1'b1 : rdAck;
    end

    assign rdValid  = state_reg;
    assign rdData   = data_reg;
    assign rdIdxOut = idx_reg;
    assign fwdCount = fwd_count_reg;

    assign accept  = rdReq & rdReady;
    assign take    = rdValid & rdAck;
    assign forward = regWrite && (wrIdx == rdIdx);

    // Select forwarded write data over the (stale) bank contents.
    always_comb begin
        read_data = reg_array[rdIdx];
        if (forward) begin
            read_data = writeData;
        end
    end

    // Next-state logic for the EMPTY/FULL slot.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            STATE_EMPTY: begin
                if (accept) begin
                    state_next = STATE_FULL;
                end
            end
            STATE_FULL: begin
                if (take && !accept) begin
                    state_next = STATE_EMPTY;
                end
            end
            default: state_next = STATE_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= STATE_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Result capture: only an accepted request changes the held snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_reg <= '0;
            idx_reg  <= '0;
        end else if (accept) begin
            data_reg <= read_data;
            idx_reg  <= rdIdx;
        end
    end

    // Saturating count of reads served by forwarding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_count_reg <= '0;
        end else if (accept && forward && (fwd_count_reg != FWD_MAX)) begin
            fwd_count_reg <= fwd_count_reg + 8'd1;
        end
    end

endmodule

// File: tb/tb_register_read_unit.sv
// Testbench for register_read_unit: directed stimulus pushes expected
// results into a queue; a monitor pops and compares each result as the
// consumer takes it.

module tb_register_read_unit;

    localparam int WIDTH = 16;

    logic               clk;
    logic               reset;
    logic [8*WIDTH-1:0] regFile;
    logic               regWrite;
    logic [2:0]         wrIdx;
    logic [WIDTH-1:0]   writeData;
    logic               rdReq;
    logic [2:0]         rdIdx;
    logic               rdReady;
    logic               rdValid;
    logic [WIDTH-1:0]   rdData;
    logic [2:0]         rdIdxOut;
    logic               rdAck;
    logic [7:0]         fwdCount;

    typedef struct packed {
        logic [2:0]       idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb_q[$];

    int pass_count;
    int check_count;
    int pop_count;

    register_read_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .regFile   (regFile),
        .regWrite  (regWrite),
        .wrIdx     (wrIdx),
        .writeData (writeData),
        .rdReq     (rdReq),
        .rdIdx     (rdIdx),
        .rdReady   (rdReady),
        .rdValid   (rdValid),
        .rdData    (rdData),
        .rdIdxOut  (rdIdxOut),
        .rdAck     (rdAck),
        .fwdCount  (fwdCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
            $display("check %-16s ok   act=0x%0h exp=0x%0h", name, act, exp);
        end else begin
            $display("FAIL %-16s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [WIDTH-1:0] val);
        regFile[idx*WIDTH +: WIDTH] = val;
    endtask

    task automatic push(input logic [2:0] idx, input logic [WIDTH-1:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Monitor: a result leaves the unit at the next edge when rdValid && rdAck.
    always @(negedge clk) begin
        if (reset && rdValid && rdAck) begin
            if (sb_q.size() == 0) begin
                check_count++;
                $display("FAIL unexpected_result act idx=%0d data=0x%0h exp=none", rdIdxOut, rdData);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                pop_count++;
                check("result_idx", 32'(rdIdxOut), 32'(e.idx));
                check("result_data", 32'(rdData), 32'(e.data));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops_before;
        logic [15:0] wd;

        pass_count  = 0;
        check_count = 0;
        pop_count   = 0;
        reset     = 1'b0;
        regFile   = '0;
        regWrite  = 1'b0;
        wrIdx     = '0;
        writeData = '0;
        rdReq     = 1'b0;
        rdIdx     = '0;
        rdAck     = 1'b0;

        // Reset state
        #1;
        check("rst_rdValid", 32'(rdValid), 32'd0);
        check("rst_rdData", 32'(rdData), 32'd0);
        check("rst_rdIdxOut", 32'(rdIdxOut), 32'd0);
        check("rst_fwdCount", 32'(fwdCount), 32'd0);
        step();
        step();
        reset = 1'b1;
        check("rdy_after_rst", 32'(rdReady), 32'd1);

        // Plain read of reg3
        set_reg(3, 16'h1234);
        rdReq = 1'b1; rdIdx = 3'd3; rdAck = 1'b1;
        push(3'd3, 16'h1234);
        step();
        rdReq = 1'b0;
        check("t1_valid", 32'(rdValid), 32'd1);
        step();
        check("t1_empty", 32'(rdValid), 32'd0);

        // Forwarding read of reg5
        set_reg(5, 16'h0001);
        regWrite = 1'b1; wrIdx = 3'd5; writeData = 16'hBEEF;
        rdReq = 1'b1; rdIdx = 3'd5; rdAck = 1'b1;
        push(3'd5, 16'hBEEF);
        step();
        regWrite = 1'b0; rdReq = 1'b0;
        check("t2_fwdCount", 32'(fwdCount), 32'd1);
        step();

        // Held snapshot while reg2 is overwritten
        set_reg(2, 16'h00AA);
        rdReq = 1'b1; rdIdx = 3'd2; rdAck = 1'b0;
        push(3'd2, 16'h00AA);
        step();
        set_reg(2, 16'h5555);
        regWrite = 1'b1; wrIdx = 3'd2; writeData = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_data", 32'(rdData), 32'h00AA);
            check("t3_hold_ready", 32'(rdReady), 32'd0);
            step();
        end
        check("t3_fwd_unchanged", 32'(fwdCount), 32'd1);
        regWrite = 1'b0; rdReq = 1'b0; rdAck = 1'b1;
        step();
        check("t3_drained", 32'(rdValid), 32'd0);

        // Back-to-back stream over all indices
        for (int i = 0; i < 8; i++) set_reg(i, 16'(16'h1000 + i * 16'h0011));
        pops_before = pop_count;
        rdReq = 1'b1; rdAck = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rdIdx = 3'(i);
            push(3'(i), 16'(16'h1000 + i * 16'h0011));
            step();
            check("t4_no_bubble", 32'(rdValid), 32'd1);
        end
        rdReq = 1'b0;
        step();
        check("t4_empty", 32'(rdValid), 32'd0);
        check("t4_result_count", 32'(pop_count - pops_before), 32'd8);

        // 300 forwarding reads: counter saturates
        rdReq = 1'b1; rdAck = 1'b1; regWrite = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wd = 16'(i) ^ 16'hA5A5;
            rdIdx = 3'(i % 8); wrIdx = 3'(i % 8); writeData = wd;
            push(3'(i % 8), wd);
            step();
            if (i == 99) check("t5_fwd_mid", 32'(fwdCount), 32'd101);
        end
        rdReq = 1'b0; regWrite = 1'b0;
        step();
        check("t5_fwd_sat", 32'(fwdCount), 32'd255);

        // Asynchronous reset while FULL
        set_reg(4, 16'hC0DE);
        rdReq = 1'b1; rdIdx = 3'd4; rdAck = 1'b0;
        step();
        rdReq = 1'b0;
        check("t6_full", 32'(rdValid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rdValid", 32'(rdValid), 32'd0);
        check("t6_rdData", 32'(rdData), 32'd0);
        check("t6_rdIdxOut", 32'(rdIdxOut), 32'd0);
        check("t6_fwdCount", 32'(fwdCount), 32'd0);
        check("t6_rdReady", 32'(rdReady), 32'd1);
        step();
        reset = 1'b1;
        rdAck = 1'b1;

        // Normal operation after reset
        set_reg(7, 16'h7777);
        rdReq = 1'b1; rdIdx = 3'd7;
        push(3'd7, 16'h7777);
        step();
        rdReq = 1'b0;
        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
